// File: rtl/or1200_keccak_cust5_seq.sv
// l.cust5 command sequencer for the or1200 Keccak extension.
// Packs absorbed GPR words into rate blocks, applies word-granular pad10*1,
// hands full blocks to an external Keccak-f core and serves digest words.
module or1200_keccak_cust5_seq #(
    parameter int DW         = 32,
    parameter int RATE_WORDS = 34,
    parameter int OUT_WORDS  = 16,
    parameter int IDXW       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_freeze,
    input  logic                       cmd_valid,
    input  logic [4:0]                 cust5_op,
    input  logic [IDXW-1:0]            cust5_limm,
    input  logic [DW-1:0]              opa,
    output logic [DW-1:0]              result,
    output logic                       result_valid,
    output logic                       busy,
    output logic                       perm_req,
    output logic [RATE_WORDS*DW-1:0]   perm_blk,
    input  logic                       perm_ack,
    input  logic [OUT_WORDS*DW-1:0]    perm_state
);

    localparam int CW = $clog2(RATE_WORDS + 1);

    localparam logic [4:0] OP_INIT   = 5'b00000;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;

    typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PERM, S_FINAL, S_DONE} state_t;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   wcnt, wcnt_nxt, wcnt_inc;
    logic [RATE_WORDS-1:0][DW-1:0]   blk, blk_nxt;
    logic [OUT_WORDS-1:0][DW-1:0]    dig, dig_nxt;
    logic                            last, last_nxt;
    logic [DW-1:0]                   result_nxt;
    logic                            rv_nxt;
    logic                            in_perm, acc;

    // req/busy derive from state so a reset drops them without a clock edge
    assign in_perm  = (state == S_PERM) || (state == S_FINAL);
    assign busy     = in_perm;
    assign perm_req = in_perm;
    assign perm_blk = blk;
    assign acc      = cmd_valid & ~ex_freeze & ~busy;
    assign wcnt_inc = wcnt + CW'(1);

    // State, buffers and store result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            blk          <= '0;
            dig          <= '0;
            last         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            wcnt         <= wcnt_nxt;
            blk          <= blk_nxt;
            dig          <= dig_nxt;
            last         <= last_nxt;
            result       <= result_nxt;
            result_valid <= rv_nxt;
        end
    end

    // Command decode, absorb/pad datapath and permutation handshake
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        blk_nxt    = blk;
        dig_nxt    = dig;
        last_nxt   = last;
        result_nxt = result;
        rv_nxt     = 1'b0;

        case (state)
            S_PERM: begin
                if (perm_ack) begin
                    blk_nxt  = '0;
                    wcnt_nxt = '0;
                    if (last) begin
                        // message ended exactly on a block boundary: all-pad block
                        blk_nxt[0][0]                 = 1'b1;
                        blk_nxt[RATE_WORDS-1][DW-1]   = 1'b1;
                        last_nxt                      = 1'b0;
                        state_nxt                     = S_FINAL;
                    end else begin
                        state_nxt = S_ABSORB;
                    end
                end
            end
            S_FINAL: begin
                if (perm_ack) begin
                    blk_nxt   = '0;
                    wcnt_nxt  = '0;
                    dig_nxt   = perm_state;
                    state_nxt = S_DONE;
                end
            end
            default: begin
                if (acc) begin
                    case (cust5_op)
                        OP_INIT: begin
                            blk_nxt   = '0;
                            dig_nxt   = '0;
                            wcnt_nxt  = '0;
                            last_nxt  = 1'b0;
                            state_nxt = S_IDLE;
                        end
                        OP_START: begin
                            blk_nxt    = '0;
                            blk_nxt[0] = opa;
                            wcnt_nxt   = CW'(1);
                            last_nxt   = 1'b0;
                            state_nxt  = S_ABSORB;
                        end
                        OP_MIDDLE: begin
                            if (state == S_ABSORB) begin
                                for (int i = 0; i < RATE_WORDS; i++)
                                    if (wcnt == CW'(i)) blk_nxt[i] = opa;
                                wcnt_nxt = wcnt_inc;
                                if (wcnt_inc == CW'(RATE_WORDS))
                                    state_nxt = S_PERM;
                            end
                        end
                        OP_END: begin
                            if (state == S_ABSORB) begin
                                for (int i = 0; i < RATE_WORDS; i++)
                                    if (wcnt == CW'(i)) blk_nxt[i] = opa;
                                wcnt_nxt = wcnt_inc;
                                if (wcnt_inc == CW'(RATE_WORDS)) begin
                                    // no room for padding: pad goes in a follow-up block
                                    last_nxt  = 1'b1;
                                    state_nxt = S_PERM;
                                end else begin
                                    // both pad bits may land in the same word
                                    for (int i = 0; i < RATE_WORDS; i++)
                                        if (wcnt_inc == CW'(i)) blk_nxt[i][0] = 1'b1;
                                    blk_nxt[RATE_WORDS-1][DW-1] = 1'b1;
                                    state_nxt = S_FINAL;
                                end
                            end
                        end
                        OP_STORE: begin
                            rv_nxt     = 1'b1;
                            result_nxt = '0;
                            if (state == S_DONE)
                                for (int i = 0; i < OUT_WORDS; i++)
                                    if (cust5_limm == IDXW'(i)) result_nxt = dig[i];
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule
